// File: rtl/aplic_cfg_arbiter.sv
// Round-robin arbiter sharing the single APLIC register-configuration port
// among NR_REQ bus requesters. One requester is granted per transaction.
// Its request is forwarded combinationally while BUSY, and the APLIC response
// is routed back to that requester only. A per-transaction timeout completes
// a stalled transaction with an error response.
//
// Handshake: a requester raises i_req_valid[k] and holds it, with stable
// payload, until it sees o_rsp_ready[k] for one cycle. On the APLIC side,
// o_cfg_valid is high while the granted request is pending. The APLIC
// completes it by pulsing i_cfg_ready with i_cfg_rdata/i_cfg_error valid in
// the same cycle.
module aplic_cfg_arbiter #(
    parameter int NR_REQ  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NR_REQ*32-1:0] i_req_addr,
    input  logic [NR_REQ-1:0]    i_req_write,
    input  logic [NR_REQ*32-1:0] i_req_wdata,
    input  logic [NR_REQ*4-1:0]  i_req_wstrb,
    input  logic [NR_REQ-1:0]    i_req_valid,
    output logic [NR_REQ*32-1:0] o_rsp_rdata,
    output logic [NR_REQ-1:0]    o_rsp_error,
    output logic [NR_REQ-1:0]    o_rsp_ready,
    output logic [31:0]          o_cfg_addr,
    output logic                 o_cfg_write,
    output logic [31:0]          o_cfg_wdata,
    output logic [3:0]           o_cfg_wstrb,
    output logic                 o_cfg_valid,
    input  logic [31:0]          i_cfg_rdata,
    input  logic                 i_cfg_error,
    input  logic                 i_cfg_ready,
    output logic [NR_REQ-1:0]    o_grant,
    output logic                 o_busy
);

    localparam int IW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NR_REQ-1:0] r_grant;
    logic [IW-1:0]     r_gidx;
    logic [IW-1:0]     r_rr_ptr;
    logic [TW-1:0]     r_timer;
    logic [IW-1:0]     w_pick;
    logic              w_pick_vld;
    logic [IW-1:0]     w_gidx_inc;
    logic              w_gvalid;
    logic              w_timeout;
    logic              w_done;

    // Index following the granted one, wrapping at NR_REQ.
    assign w_gidx_inc = (r_gidx == IW'(NR_REQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_gvalid   = i_req_valid[r_gidx];
    // Timeout fires on the last allowed BUSY cycle unless the APLIC answers in it.
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1)) && !i_cfg_ready;

    assign o_grant = r_grant;
    assign o_busy  = (r_state == ST_BUSY);

    // Round-robin pick: first valid requester scanning from r_rr_ptr upward with wrap.
    always_comb begin
        int w_idx;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_idx      = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NR_REQ) begin
                w_idx = w_idx - NR_REQ;
            end
            if (!w_pick_vld && i_req_valid[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'(w_idx);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, forwarded request and routed response; everything forced to 0 in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        o_cfg_addr  = '0;
        o_cfg_write = 1'b0;
        o_cfg_wdata = '0;
        o_cfg_wstrb = '0;
        o_cfg_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_error = '0;
        o_rsp_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_cfg_addr  = i_req_addr[int'(r_gidx)*32 +: 32];
                o_cfg_write = i_req_write[r_gidx];
                o_cfg_wdata = i_req_wdata[int'(r_gidx)*32 +: 32];
                o_cfg_wstrb = i_req_wstrb[int'(r_gidx)*4 +: 4];
                o_cfg_valid = w_gvalid && !w_timeout;
                if (!w_gvalid) begin
                    // Requester withdrew its request: abandon silently.
                    w_done = 1'b1;
                end else if (i_cfg_ready) begin
                    o_rsp_ready[r_gidx]                 = 1'b1;
                    o_rsp_error[r_gidx]                 = i_cfg_error;
                    o_rsp_rdata[int'(r_gidx)*32 +: 32]  = i_cfg_rdata;
                    w_done                              = 1'b1;
                end else if (w_timeout) begin
                    o_rsp_ready[r_gidx] = 1'b1;
                    o_rsp_error[r_gidx] = 1'b1;
                    w_done              = 1'b1;
                end
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (i_rst) begin
            o_cfg_addr  = '0;
            o_cfg_write = 1'b0;
            o_cfg_wdata = '0;
            o_cfg_wstrb = '0;
            o_cfg_valid = 1'b0;
            o_rsp_rdata = '0;
            o_rsp_error = '0;
            o_rsp_ready = '0;
        end
    end

    // Grant, round-robin pointer and BUSY timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_pick_vld) begin
                        r_gidx  <= w_pick;
                        r_grant <= NR_REQ'(1) << w_pick;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_gidx_inc;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/aplic_cfg_arbiter.md
Name: aplic_cfg_arbiter

Overview:
Round-robin arbiter that shares the single APLIC register-configuration port (32-bit address/data, valid/ready handshake) among NR_REQ bus requesters, e.g. the hart-side bus and the debug/boot loader. It grants one requester per transaction and forwards that requester's request to the APLIC. It routes the response back to the granted requester only. A per-transaction timeout returns an error response if the APLIC never asserts ready.

Parameters:
NR_REQ, 2, number of requesters (2..8)
TIMEOUT, 64, cycles in BUSY before error completion (0 = timeout disabled)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req_addr  in  NR_REQ*32  per-requester address, slice k = bits [32k+31:32k]
i_req_write  in  NR_REQ  per-requester write flag
i_req_wdata  in  NR_REQ*32  per-requester write data
i_req_wstrb  in  NR_REQ*4  per-requester byte strobes
i_req_valid  in  NR_REQ  per-requester valid, held until ready
o_rsp_rdata  out  NR_REQ*32  per-requester read data
o_rsp_error  out  NR_REQ  per-requester error
o_rsp_ready  out  NR_REQ  per-requester completion strobe
o_cfg_addr  out  32  to APLIC
o_cfg_write  out  1  to APLIC
o_cfg_wdata  out  32  to APLIC
o_cfg_wstrb  out  4  to APLIC
o_cfg_valid  out  1  to APLIC
i_cfg_rdata  in  32  from APLIC
i_cfg_error  in  1  from APLIC
i_cfg_ready  in  1  from APLIC
o_grant  out  NR_REQ  one-hot registered grant (0 when idle)
o_busy  out  1  high in BUSY

Behaviour:
- Clock is i_clk. Reset is i_rst, synchronous, active-high.
- States: IDLE, BUSY. Reset -> IDLE, grant=0, rr_ptr=0, timer=0. In reset, all o_rsp_* = 0 and all o_cfg_* = 0.
- IDLE, any i_req_valid set: pick the first valid index scanning rr_ptr, rr_ptr+1, ... with modulo-NR_REQ wrap. Register it in grant and go to BUSY. Nothing is forwarded in this cycle (1-cycle arbitration latency).
- BUSY:
  - o_cfg_* = the granted requester's slice, muxed combinationally from live inputs.
  - o_cfg_valid = i_req_valid[g].
- BUSY, i_cfg_ready=1 (and the timeout has not fired):
  - o_rsp_ready[g]=1, o_rsp_rdata[g]=i_cfg_rdata, o_rsp_error[g]=i_cfg_error, all in the same cycle.
  - Next state IDLE; rr_ptr <= (g+1) mod NR_REQ; timer cleared.
- Non-granted requesters always see rsp_ready=0, rdata=0, error=0.
- Minimum transaction: valid at cycle t, slave valid at t+1, completion at t+1 if the APLIC is ready immediately. Back-to-back transactions have a 1-cycle IDLE gap.
- Timer counts the BUSY cycles without ready.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 while i_cfg_ready=0: force o_rsp_ready[g]=1, o_rsp_error[g]=1, o_rsp_rdata[g]=0.
  - In that same cycle o_cfg_valid=0. Go to IDLE and advance rr_ptr as for normal completion.
  - If i_cfg_ready=1 in the timeout cycle, the normal completion wins.
- Granted requester drops valid in BUSY (protocol violation): o_cfg_valid=0, no response, return to IDLE next cycle. rr_ptr advances past g.
- Requests arriving in BUSY wait. Requests never lose their place: after g completes, scanning restarts at g+1, so each requester waits at most NR_REQ-1 transactions.
- Simultaneous requests in IDLE: round-robin order only; no fixed priority beyond rr_ptr.
- i_rst asserted mid-transaction: the next edge returns to IDLE with grant=0. The outstanding transaction is dropped without a response, and the requester must reissue.
- Outputs o_cfg_* are combinational from the grant register and requester inputs. o_grant and o_busy are registered.

Test Plan:
- Single read: req0 valid, addr 0x0000_0004; APLIC ready 2 cycles after o_cfg_valid, rdata 0xDEAD_BEEF -> o_rsp_ready[0] pulses once with rdata 0xDEAD_BEEF, error 0; o_rsp_ready[1]=0 throughout.
- Contention: req0 and req1 valid simultaneously after reset, APLIC always ready -> grant order 0,1,0,1 across four transactions. Each completes 1 cycle after grant, with a 1-cycle idle gap between them.
- Fairness: req0 holds valid continuously while req1 asserts once -> req1 is served no later than the second transaction after its assertion.
- Timeout: TIMEOUT=8, APLIC never ready -> o_rsp_ready[g]=1 and error=1 exactly 8 cycles after BUSY entry, rdata 0, o_cfg_valid=0 in that cycle, then IDLE.
- Ready on timeout cycle: APLIC ready coincides with timer=TIMEOUT-1, error=0, rdata 0x1234_5678 -> normal response delivered, error=0.
- Reset mid-transaction: i_rst for 1 cycle while BUSY -> next cycle o_grant=0, o_busy=0, o_cfg_valid=0, no o_rsp_ready pulse. A following request from req1 is granted first (rr_ptr=0 after reset; req0 idle).
